// File: rtl/mem_arbiter.sv
// Shared register-file arbiter: one core at a time gets a three-cycle IDLE/ACCESS/DONE transaction.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed lowest-index priority.
module mem_arbiter #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned DATA_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CORES-1:0]          req,
    input  logic [NUM_CORES-1:0]          we,
    input  logic [NUM_CORES*ADDR_W-1:0]   addr,
    input  logic [NUM_CORES*DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]             reg_bus,
    output logic [NUM_CORES-1:0]          gnt,
    output logic [NUM_CORES-1:0]          ack,
    output logic [DATA_W-1:0]             rdata,
    output logic [DATA_W-1:0]             reg_data,
    output logic [(2**ADDR_W)-1:0]        reg_write,
    output logic [(2**ADDR_W)-1:0]        reg_read,
    output logic                          busy
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam int unsigned IdxW     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e                 state_q;
    logic                   we_q;
    logic                   found;
    logic [IdxW-1:0]        win_idx;
    logic [NUM_CORES-1:0]   win_oh;
    logic [ADDR_W-1:0]      win_addr;
    logic [NUM_REGS-1:0]    sel_oh;
    logic [DATA_W-1:0]      win_wdata;
    logic                   win_we;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [IdxW-1:0]        ptr_q;
    logic [IdxW-1:0]        win_q;
    logic [IdxW-1:0]        cand;

    // Search upward from the core after the last winner, wrapping around.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int unsigned k = 1; k <= NUM_CORES; k++) begin
            cand = IdxW'((32'(ptr_q) + k) % NUM_CORES);
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end
`else
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (!found && req[IdxW'(i)]) begin
                found   = 1'b1;
                win_idx = IdxW'(i);
            end
        end
    end
`endif

    always_comb begin
        win_oh    = NUM_CORES'(1) << win_idx;
        win_addr  = addr[win_idx*ADDR_W +: ADDR_W];
        win_wdata = wdata[win_idx*DATA_W +: DATA_W];
        win_we    = we[win_idx];
        sel_oh    = NUM_REGS'(1) << win_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            we_q      <= 1'b0;
            gnt       <= '0;
            ack       <= '0;
            rdata     <= '0;
            reg_data  <= '0;
            reg_write <= '0;
            reg_read  <= '0;
            busy      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr_q     <= IdxW'(NUM_CORES - 1);
            win_q     <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (found) begin
                        state_q  <= StAccess;
                        we_q     <= win_we;
                        gnt      <= win_oh;
                        reg_data <= win_wdata;
                        busy     <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        win_q    <= win_idx;
`endif
                        // Strobes are decoded here so they are registered during ACCESS.
                        if (win_we) begin
                            reg_write <= sel_oh;
                        end else begin
                            reg_read  <= sel_oh;
                        end
                    end
                end
                StAccess: begin
                    reg_write <= '0;
                    reg_read  <= '0;
                    if (!we_q) begin
                        rdata <= reg_bus;
                    end
                    ack     <= gnt;
                    state_q <= StDone;
                end
                StDone: begin
                    ack     <= '0;
                    gnt     <= '0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    ptr_q   <= win_q;
`endif
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table of transactions plus hand-written corner cases,
// with a scoreboard that checks every ack and read result.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic [15:0] reg_bus;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [15:0] rdata;
    logic [15:0] reg_data;
    logic [7:0]  reg_write;
    logic [7:0]  reg_read;
    logic        busy;

    mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .reg_bus   (reg_bus),
        .gnt       (gnt),
        .ack       (ack),
        .rdata     (rdata),
        .reg_data  (reg_data),
        .reg_write (reg_write),
        .reg_read  (reg_read),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file driven by the DUT strobes.
    logic [15:0] mem [8] = '{default: 16'h0};

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (reg_write[i]) mem[i] <= reg_data;
        end
    end

    always_comb begin
        reg_bus = '0;
        for (int i = 0; i < 8; i++) begin
            if (reg_read[i]) reg_bus = mem[i];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0]  ack_exp;
        bit          is_read;
        logic [15:0] rd_exp;
    } sb_t;

    sb_t sb [$];

    always @(negedge clk) begin
        if (rst_n && ack != 4'h0) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_ack", {60'h0, ack}, 64'h0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("sb_ack", {60'h0, ack}, {60'h0, e.ack_exp});
                if (e.is_read) chk("sb_rdata", {48'h0, rdata}, {48'h0, e.rd_exp});
            end
        end
    end

    logic [15:0] shadow [8] = '{default: 16'h0};
    logic [15:0] last_rd = 16'h0;

    typedef struct {
        int unsigned core;
        bit          is_wr;
        int unsigned a;
        logic [15:0] d;
    } vec_t;

    vec_t vecs [10];

    task automatic drive(input int unsigned c, input bit w, input int unsigned a,
                         input logic [15:0] d);
        logic [3:0]  r;
        logic [3:0]  wv;
        logic [11:0] av;
        logic [63:0] dv;
        r  = 4'h0;
        r[c] = 1'b1;
        wv = 4'($urandom);
        wv[c] = w;
        av = 12'($urandom);
        av[c*3 +: 3] = 3'(a);
        dv = {$urandom, $urandom};
        dv[c*16 +: 16] = d;
        req = r; we = wv; addr = av; wdata = dv;
    endtask

    // Starts and finishes on a falling edge with the DUT in IDLE.
    task automatic do_txn(input int unsigned c, input bit w, input int unsigned a,
                          input logic [15:0] d);
        sb_t e;
        logic [3:0] oh;
        logic [7:0] sel;
        oh  = 4'h0;
        oh[c] = 1'b1;
        sel = 8'h0;
        sel[a] = 1'b1;
        drive(c, w, a, d);
        e.ack_exp = oh;
        e.is_read = !w;
        e.rd_exp  = shadow[a];
        sb.push_back(e);
        if (w) shadow[a] = d;
        else   last_rd = shadow[a];
        @(negedge clk);
        chk("access_gnt", {60'h0, gnt}, {60'h0, oh});
        chk("access_busy", {63'h0, busy}, 64'h1);
        chk("access_reg_write", {56'h0, reg_write}, w ? {56'h0, sel} : 64'h0);
        chk("access_reg_read", {56'h0, reg_read}, w ? 64'h0 : {56'h0, sel});
        if (w) chk("access_reg_data", {48'h0, reg_data}, {48'h0, d});
        // Withdraw the request and scramble inputs; the latched copies must be used.
        req = 4'h0; we = ~we; addr = ~addr; wdata = ~wdata;
        @(negedge clk);
        chk("done_ack", {60'h0, ack}, {60'h0, oh});
        chk("done_strobes", {48'h0, reg_write, reg_read}, 64'h0);
        @(negedge clk);
        chk("idle_outputs", {51'h0, busy, gnt, ack, reg_write, reg_read}, 64'h0);
        chk("idle_rdata_hold", {48'h0, rdata}, {48'h0, last_rd});
    endtask

    int unsigned exp_order [4];
    logic [15:0] cdata [4];
    int unsigned caddr [4];

    initial begin
        vecs[0] = '{1, 1'b1, 5, 16'hA5A5};
        vecs[1] = '{2, 1'b0, 5, 16'h0000};
        vecs[2] = '{0, 1'b1, 0, 16'h1234};
        vecs[3] = '{3, 1'b1, 7, 16'hFFFF};
        vecs[4] = '{3, 1'b0, 7, 16'h0000};
        vecs[5] = '{1, 1'b0, 3, 16'h0000};
        vecs[6] = '{0, 1'b0, 0, 16'h0000};
        vecs[7] = '{2, 1'b1, 5, 16'h5A5A};
        vecs[8] = '{0, 1'b0, 5, 16'h0000};
        vecs[9] = '{3, 1'b1, 6, 16'h0F0F};
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 3, 0, 3};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        cdata = '{16'h1111, 16'h0, 16'h0, 16'h3333};
        caddr = '{1, 0, 0, 2};

        rst_n = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_outputs", {13'h0, busy, gnt, ack, reg_write, reg_read, reg_data, rdata},
            64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            chk("idle_quiet", {51'h0, busy, gnt, reg_write, reg_read, 4'h0}, 64'h0);
            @(negedge clk);
        end

        foreach (vecs[i]) do_txn(vecs[i].core, vecs[i].is_wr, vecs[i].a, vecs[i].d);

        // Reset during a write's ACCESS cycle: strobes drop at once, no ack, no write lands.
        drive(2, 1'b1, 4, 16'hBEEF);
        @(negedge clk);
        chk("rst_mid_pre_write", {56'h0, reg_write}, 64'h10);
        #1 rst_n = 1'b0;
        req = 4'h0;
        #1;
        chk("rst_mid_outputs", {43'h0, busy, gnt, ack, reg_write, reg_read}, 64'h0);
        @(negedge clk);
        chk("rst_mid_no_ack", {60'h0, ack}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Cores 0 and 3 hold their requests across four transactions.
        req = 4'b1001; we = 4'b1111;
        addr = {3'(caddr[3]), 3'd0, 3'd0, 3'(caddr[0])};
        wdata = {cdata[3], 16'h0, 16'h0, cdata[0]};
        for (int t = 0; t < 4; t++) begin
            sb_t e;
            logic [3:0] oh;
            oh = 4'h0;
            oh[exp_order[t]] = 1'b1;
            e.ack_exp = oh;
            e.is_read = 1'b0;
            e.rd_exp  = 16'h0;
            sb.push_back(e);
            shadow[caddr[exp_order[t]]] = cdata[exp_order[t]];
            @(negedge clk);
            chk("contention_gnt", {60'h0, gnt}, {60'h0, oh});
            if (t == 3) req = 4'h0;
            repeat (2) @(negedge clk);
        end

        do_txn(1, 1'b0, 1, 16'h0);
        do_txn(2, 1'b0, 2, 16'h0);
        do_txn(0, 1'b0, 4, 16'h0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
